// File: rtl/updown_mod_counter_if.sv
// Signal bundle between the up/down modulo counter and whoever controls it.
// There is no valid/ready handshake on this bus: the controller holds
// en/up_dn/sat/load/load_val steady across a rising clk edge, and the counter
// presents count/tc (registered) and zero (combinational from count) for the
// following cycle.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             zero;

  // Controller side
  modport master (
    output en, up_dn, sat, load, load_val,
    input  count, tc, zero
  );

  // Counter side
  modport slave (
    input  en, up_dn, sat, load, load_val,
    output count, tc, zero
  );
endinterface

// File: rtl/updown_mod_counter.sv
// General-purpose up/down counter, modulo MAX_VAL+1, with an enable
// prescaler, synchronous clamped parallel load, wrap/saturate boundary mode
// and a registered one-cycle terminal-count pulse.
// Legal parameters: WIDTH 2..16, MAX_VAL <= 2^WIDTH-1, PRESCALE 1..256,
// RST_VAL <= MAX_VAL.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 15,
  parameter int PRESCALE = 1,
  parameter int RST_VAL  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_mod_counter_if.slave  bus
);

  // Prescaler counter width: ceil(log2(PRESCALE)), never below one bit.
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RST_VAL);
  localparam logic [PCW-1:0]   PC_LAST = PCW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic             tc_q, tc_d;
  logic             step;

  // Next-state: load beats step beats hold. Boundary checks happen before
  // any arithmetic, so count never leaves 0..MAX_VAL even when MAX_VAL is not
  // a power of two.
  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    tc_d    = 1'b0;
    step    = 1'b0;

    if (bus.load) begin
      count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
      pc_d    = '0;
    end else if (bus.en) begin
      if (pc_q == PC_LAST) begin
        pc_d = '0;
        step = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end

    if (step) begin
      if (bus.up_dn) begin
        if (count_q == MAX_C) begin
          tc_d = 1'b1;
          if (!bus.sat) begin
            count_d = '0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (!bus.sat) begin
            count_d = MAX_C;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // State registers; reset drops pending prescale progress and any tc pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_C;
      pc_q    <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
    end
  end

  // Outputs: count and tc registered, zero decoded from the registered count.
  always_comb begin
    bus.count = count_q;
    bus.tc    = tc_q;
    bus.zero  = (count_q == '0);
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter. Three instances share one stimulus stream:
// u_a defaults (mod 16), u_b MAX_VAL=9 (mod 10), u_c PRESCALE=3.
// Each vector names the instance whose outputs it checks.
module tb_updown_mod_counter;

  localparam int SEL_A = 0;
  localparam int SEL_B = 1;
  localparam int SEL_C = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(4)) if_a ();
  updown_mod_counter_if #(.WIDTH(4)) if_b ();
  updown_mod_counter_if #(.WIDTH(4)) if_c ();

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1), .RST_VAL(0)) u_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .RST_VAL(0)) u_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(3), .RST_VAL(0)) u_c (
    .clk(clk), .reset(reset), .bus(if_c)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {sel[1:0], count[3:0], tc, zero}
  logic [7:0] exp_q[$];

  typedef struct {
    bit         en;
    bit         up;
    bit         sat;
    bit         ld;
    logic [3:0] lv;
    int         sel;
    logic [3:0] cnt;
    bit         tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit up, bit sat, bit ld, logic [3:0] lv,
                              int sel, logic [3:0] cnt, bit tc);
    vec_t v;
    v.en = en; v.up = up; v.sat = sat; v.ld = ld; v.lv = lv;
    v.sel = sel; v.cnt = cnt; v.tc = tc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input bit up, input bit sat, input bit ld,
                       input logic [3:0] lv);
    if_a.en = en; if_a.up_dn = up; if_a.sat = sat; if_a.load = ld; if_a.load_val = lv;
    if_b.en = en; if_b.up_dn = up; if_b.sat = sat; if_b.load = ld; if_b.load_val = lv;
    if_c.en = en; if_c.up_dn = up; if_c.sat = sat; if_c.load = ld; if_c.load_val = lv;
  endtask

  task automatic read_out(input int sel, output logic [3:0] c, output logic t,
                          output logic z);
    case (sel)
      SEL_A:   begin c = if_a.count; t = if_a.tc; z = if_a.zero; end
      SEL_B:   begin c = if_b.count; t = if_b.tc; z = if_b.zero; end
      default: begin c = if_c.count; t = if_c.tc; z = if_c.zero; end
    endcase
  endtask

  task automatic compare_out(input string tag);
    logic [7:0] e;
    logic [3:0] c;
    logic       t, z;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      read_out(int'(e[7:6]), c, t, z);
      check({tag, " count"}, 32'(c), 32'(e[5:2]));
      check({tag, " tc"},    32'(t), 32'(e[1]));
      check({tag, " zero"},  32'(z), 32'(e[0]));
    end
  endtask

  // Drive one cycle of inputs, push the expectation, compare after the edge.
  task automatic apply(input bit en, input bit up, input bit sat, input bit ld,
                       input logic [3:0] lv, input int sel, input logic [3:0] cnt,
                       input bit tc, input string tag);
    drive(en, up, sat, ld, lv);
    exp_q.push_back({2'(sel), cnt, tc, (cnt == 4'd0)});
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  // Direct check of one instance between edges (used around async reset).
  task automatic check_now(input int sel, input logic [3:0] cnt, input bit tc,
                           input string tag);
    logic [3:0] c;
    logic       t, z;
    read_out(sel, c, t, z);
    check({tag, " count"}, 32'(c), 32'(cnt));
    check({tag, " tc"},    32'(t), 32'(tc));
    check({tag, " zero"},  32'(z), 32'(cnt == 4'd0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- test ----------------
  initial begin
    // Default down count on u_a: first step wraps 0->15, then 14..0, then 15.
    for (int k = 1; k <= 17; k++)
      tbl.push_back(mk(1, 0, 0, 0, 4'd0, SEL_A, 4'((32 - k) % 16), (k == 1) || (k == 17)));
    // Modulo-10 up count on u_b after a load of 0.
    tbl.push_back(mk(1, 1, 0, 1, 4'd0, SEL_B, 4'd0, 0));
    for (int k = 1; k <= 12; k++)
      tbl.push_back(mk(1, 1, 0, 0, 4'd0, SEL_B, 4'(k % 10), k == 10));
    // Prescaler on u_c: 9 enabled, 4 idle, 3 enabled.
    tbl.push_back(mk(0, 1, 0, 1, 4'd0, SEL_C, 4'd0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1, 1, 0, 0, 4'd0, SEL_C, 4'(k / 3), 0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(0, 1, 0, 0, 4'd0, SEL_C, 4'd3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'd0, SEL_C, 4'd3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'd0, SEL_C, 4'd3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'd0, SEL_C, 4'd4, 0));

    // Reset phase
    reset = 1'b0;
    drive(1, 0, 0, 0, 4'd0);
    #12;
    check_now(SEL_A, 4'd0, 0, "rst_a");
    check_now(SEL_B, 4'd0, 0, "rst_b");
    check_now(SEL_C, 4'd0, 0, "rst_c");
    #8;
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].ld, tbl[i].lv,
            tbl[i].sel, tbl[i].cnt, tbl[i].tc, $sformatf("vec%0d", i));

    // Saturate up at 15, then down without tc.
    apply(0, 1, 1, 1, 4'd14, SEL_A, 4'd14, 0, "sat_ld");
    apply(1, 1, 1, 0, 4'd0,  SEL_A, 4'd15, 0, "sat_up1");
    apply(1, 1, 1, 0, 4'd0,  SEL_A, 4'd15, 1, "sat_up2");
    apply(1, 1, 1, 0, 4'd0,  SEL_A, 4'd15, 1, "sat_up3");
    apply(1, 1, 1, 0, 4'd0,  SEL_A, 4'd15, 1, "sat_up4");
    apply(1, 0, 1, 0, 4'd0,  SEL_A, 4'd14, 0, "sat_dn1");
    apply(1, 0, 1, 0, 4'd0,  SEL_A, 4'd13, 0, "sat_dn2");
    // Saturate down at 0, then switch to wrap.
    apply(0, 0, 1, 1, 4'd0,  SEL_A, 4'd0,  0, "satz_ld");
    apply(1, 0, 1, 0, 4'd0,  SEL_A, 4'd0,  1, "satz1");
    apply(1, 0, 1, 0, 4'd0,  SEL_A, 4'd0,  1, "satz2");
    apply(1, 0, 0, 0, 4'd0,  SEL_A, 4'd15, 1, "wrapz");
    apply(1, 0, 0, 0, 4'd0,  SEL_A, 4'd14, 0, "wrapz_next");
    // Load right after a boundary step clears tc.
    apply(1, 0, 0, 1, 4'd0,  SEL_A, 4'd0,  0, "ldtc_ld0");
    apply(1, 0, 0, 0, 4'd0,  SEL_A, 4'd15, 1, "ldtc_wrap");
    apply(1, 0, 0, 1, 4'd3,  SEL_A, 4'd3,  0, "ldtc_ld3");

    // Load clamp and priority over step (u_b), pc clear (u_c).
    apply(0, 1, 0, 1, 4'd5,  SEL_B, 4'd5,  0, "clamp_ld5");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd5,  0, "clamp_pc1");
    apply(1, 1, 0, 1, 4'd13, SEL_B, 4'd9,  0, "clamp_13");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd13, 0, "pcclr1");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd13, 0, "pcclr2");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd14, 0, "pcclr3");
    apply(0, 1, 0, 1, 4'd10, SEL_B, 4'd9,  0, "clamp_10");
    apply(0, 1, 0, 1, 4'd8,  SEL_B, 4'd8,  0, "load_8");

    // Prescale progress survives en=0.
    apply(0, 1, 0, 1, 4'd0,  SEL_C, 4'd0,  0, "hold_ld");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd0,  0, "hold_e1");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd0,  0, "hold_e2");
    apply(0, 1, 0, 0, 4'd0,  SEL_C, 4'd0,  0, "hold_i1");
    apply(0, 1, 0, 0, 4'd0,  SEL_C, 4'd0,  0, "hold_i2");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd1,  0, "hold_e3");

    // Async reset discards an in-flight tc pulse.
    apply(0, 1, 0, 1, 4'd15, SEL_A, 4'd15, 0, "art_ld");
    apply(1, 1, 0, 0, 4'd0,  SEL_A, 4'd0,  1, "art_wrap");
    #2 reset = 1'b0;
    #1 check_now(SEL_A, 4'd0, 0, "art_rst");
    #3 reset = 1'b1;

    // Async reset mid-count with pc=2 on u_c.
    apply(0, 1, 0, 1, 4'd6,  SEL_C, 4'd6,  0, "arc_ld");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd6,  0, "arc_e1");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd6,  0, "arc_e2");
    #2 reset = 1'b0;
    #1 check_now(SEL_C, 4'd0, 0, "arc_rst");
    #3 reset = 1'b1;
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd0,  0, "arc_p1");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd0,  0, "arc_p2");
    apply(1, 1, 0, 0, 4'd0,  SEL_C, 4'd1,  0, "arc_p3");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the fixed 4-bit down counter.
- Counts up or down, selected at run time, modulo MAX_VAL+1.
- Adds an enable prescaler, synchronous parallel load, a wrap/saturate mode select, and a registered terminal-count pulse.
- Used as the general-purpose timing/event counter in lab designs; drives displays and sequencer timeouts.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..16.
- MAX_VAL, 15: highest count value; the count sequence is 0..MAX_VAL. Must satisfy MAX_VAL <= 2^WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step; 1 means step on every enabled cycle. Legal range 1..256.
- RST_VAL, 0: count value loaded by reset. Must satisfy RST_VAL <= MAX_VAL.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  count enable; gates the prescaler and step logic.
- up_dn  in  1  direction: 1 = count up, 0 = count down.
- sat  in  1  boundary mode: 1 = saturate at the end value, 0 = wrap around.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide per event.
- zero  out  1  combinational flag, count == 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - count = RST_VAL, tc = 0, prescaler counter = 0.
  - zero follows count.
  - Deassertion takes effect at the next rising clk edge.
- Priority per edge: reset > load > step > hold.
- Load (load=1):
  - count <= min(load_val, MAX_VAL); out-of-range values clamp to MAX_VAL.
  - Prescaler counter clears; tc <= 0.
  - en is ignored in a load cycle.
- Prescaler:
  - An internal counter pc (ceil(log2(PRESCALE)) bits, min 1) increments on each cycle with en=1 and load=0.
  - A step occurs in the cycle where en=1 and pc == PRESCALE-1; pc then wraps to 0.
  - With en=0, pc holds.
  - PRESCALE=1 yields a step on every enabled cycle.
- Step, up (up_dn=1):
  - count < MAX_VAL: count+1.
  - count == MAX_VAL, sat=0: count -> 0, tc <= 1.
  - count == MAX_VAL, sat=1: count holds at MAX_VAL, tc <= 1.
- Step, down (up_dn=0):
  - count > 0: count-1.
  - count == 0, sat=0: count -> MAX_VAL, tc <= 1.
  - count == 0, sat=1: count holds at 0, tc <= 1.
- tc:
  - Asserted in the cycle after a boundary step (registered with count), for exactly one cycle.
  - tc = 0 in every cycle where no boundary step occurred on the previous edge.
  - In saturate mode, tc pulses on every step attempted at the boundary.
- up_dn and sat are sampled only on step edges; changing them mid-prescale is legal and the new value applies at the next step.
- Arithmetic: no intermediate overflow. A non-power-of-two MAX_VAL never produces values > MAX_VAL.
- Reset mid-operation:
  - Returns to RST_VAL immediately (asynchronously).
  - Any pending prescale progress and any in-flight tc are discarded.

Test Plan:
- Reset and default down count, defaults: reset=0 for 20 ns, then en=1, up_dn=0, sat=0.
  - -> count 0 during reset.
  - Then 15, 14, ..., 0, 15: tc=1 for one cycle following the 0->15 wrap; zero=1 while count=0.
- Modulo-10 up count, WIDTH=4, MAX_VAL=9, up_dn=1, sat=0: 12 enabled cycles.
  - -> 1..9, 0, 1, 2; never exceeds 9; exactly one tc pulse, after the 9->0 step.
- Prescaler, PRESCALE=3, up: en=1 for 9 cycles, then en=0 for 4 cycles, then en=1 for 3 cycles.
  - -> count steps every 3rd enabled cycle: 0->3 after the first 9 cycles.
  - Holds at 3 during en=0 (pc preserved); reaches 4 after 3 more enabled cycles.
- Saturate mode, sat=1: load_val=14, load=1 for one cycle; then up for 4 steps.
  - -> 14, 15, 15, 15; tc pulses on each of the 3 steps attempted at 15.
  - Then down for 2 steps -> 14, 13, with tc=0.
- Load clamp and priority, MAX_VAL=9: load=1, load_val=13 with en=1 in the same cycle.
  - -> count=9, no step that cycle, tc=0, pc cleared.
- Asynchronous reset mid-count: count=6, PRESCALE=3 with pc=2; pull reset low between clock edges.
  - -> count=RST_VAL and tc=0 within the same cycle, without waiting for a clk edge.
  - After release, the first step requires 3 full enabled cycles.
